// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared definitions for the RTC multiplexed-bus initiators
//
// Purpose:
//   Contains the reader FSM state encoding.
//   Contains the RTC register map constants.
//   Contains the inactive levels of the RTC control pins.
//   Contains a BCD validity helper.
// Ports: none (package).
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_TURN,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_DONE
  } rd_state_t;

  // RTC register map
  localparam logic [7:0] RTC_ADDR_SECONDS = 8'h00;
  localparam logic [7:0] RTC_ADDR_MINUTES = 8'h02;
  localparam logic [7:0] RTC_ADDR_HOURS   = 8'h04;
  localparam logic [7:0] RTC_ADDR_DATE    = 8'h07;
  localparam logic [7:0] RTC_ADDR_MONTH   = 8'h08;
  localparam logic [7:0] RTC_ADDR_YEAR    = 8'h09;
  localparam logic [7:0] RTC_CMD_TRANSFER = 8'hF0;

  // Idle levels of the active-low control pins
  localparam logic RTC_CS_N_INACTIVE = 1'b1;
  localparam logic RTC_WR_N_INACTIVE = 1'b1;
  localparam logic RTC_RD_N_INACTIVE = 1'b1;

  // True when both nibbles are valid decimal digits
  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtl/rtc_phase_timer.sv - loadable down-counter that times bus phases
//
// Purpose:
//   Counts down from a loaded value.
//   Stops at zero.
//   A state that loads N-1 on entry therefore lasts N cycles.
//   The state leaves on the cycle where o_zero is high.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   i_load     load i_load_val on this edge
//   i_load_val value to load
//   o_zero     counter is at zero
module rtc_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/rtc_reg_reader.sv
// rtl/rtc_reg_reader.sv - reads one register from the multiplexed-bus RTC
//
// Purpose:
//   Runs an address phase with the wr_n latch strobe.
//   Turns the bus around for one cycle.
//   Runs a data phase with the rd_n strobe.
//   Samples bus_in, then returns the byte with a one-cycle done pulse.
//   All outputs are registered.
//   Each output is loaded from the state the FSM is entering, so the pins
//   always match the current state.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   enable          low aborts like reset, but keeps data_out/bcd_ok
//   start, addr     read request and register address (sampled in IDLE)
//   bus_in          AD bus input side
//   bus_out, bus_oe AD bus output side and its pad enable
//   rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n   RTC control pins
//   data_out, done, busy, bcd_ok           result interface
module rtc_reg_reader
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP  = 2,
  parameter int T_STROBE = 4,
  parameter int T_HOLD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       rtc_cs_n,
  output logic       rtc_ad,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] data_out,
  output logic       done,
  output logic       busy,
  output logic       bcd_ok
);

  localparam int T_MAX = (T_SETUP > T_STROBE) ?
                         ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                         ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  localparam int TW = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] LD_SETUP  = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] LD_STROBE = TW'(T_STROBE - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(T_HOLD - 1);

  rd_state_t r_state;
  rd_state_t w_next_state;

  logic [7:0]    r_addr;
  logic [7:0]    r_capture;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_load_val;
  logic          w_tmr_zero;
  logic          w_next_addr_ph;
  logic          w_next_data_ph;
  logic          w_next_cs;
  logic [7:0]    w_addr_sel;

  rtc_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_load_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (start)      w_next_state = ST_A_SETUP;
        ST_A_SETUP:  if (w_tmr_zero) w_next_state = ST_A_STROBE;
        ST_A_STROBE: if (w_tmr_zero) w_next_state = ST_A_HOLD;
        ST_A_HOLD:   if (w_tmr_zero) w_next_state = ST_TURN;
        ST_TURN:                     w_next_state = ST_D_SETUP;
        ST_D_SETUP:  if (w_tmr_zero) w_next_state = ST_D_STROBE;
        ST_D_STROBE: if (w_tmr_zero) w_next_state = ST_D_HOLD;
        ST_D_HOLD:   if (w_tmr_zero) w_next_state = ST_DONE;
        ST_DONE:                     w_next_state = ST_IDLE;
        default:                     w_next_state = ST_IDLE;
      endcase
    end
  end

  // Reload the timer on every state change with the duration of the new state.
  always_comb begin
    w_tmr_load     = (w_next_state != r_state);
    w_tmr_load_val = '0;
    case (w_next_state)
      ST_A_SETUP, ST_D_SETUP:   w_tmr_load_val = LD_SETUP;
      ST_A_STROBE, ST_D_STROBE: w_tmr_load_val = LD_STROBE;
      ST_A_HOLD, ST_D_HOLD:     w_tmr_load_val = LD_HOLD;
      default:                  w_tmr_load_val = '0;
    endcase
  end

  assign w_next_addr_ph = (w_next_state == ST_A_SETUP) || (w_next_state == ST_A_STROBE) ||
                          (w_next_state == ST_A_HOLD);
  assign w_next_data_ph = (w_next_state == ST_D_SETUP) || (w_next_state == ST_D_STROBE) ||
                          (w_next_state == ST_D_HOLD);
  assign w_next_cs      = w_next_addr_ph || w_next_data_ph || (w_next_state == ST_TURN);
  // On the accepting edge r_addr is not loaded yet, so drive the pin from addr directly.
  assign w_addr_sel     = (r_state == ST_IDLE) ? addr : r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_capture <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      rtc_cs_n  <= RTC_CS_N_INACTIVE;
      rtc_ad    <= 1'b0;
      rtc_wr_n  <= RTC_WR_N_INACTIVE;
      rtc_rd_n  <= RTC_RD_N_INACTIVE;
      data_out  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bcd_ok    <= 1'b0;
    end else begin
      if (enable && (r_state == ST_IDLE) && start) begin
        r_addr <= addr;
      end
      // Sample on the edge that ends the last strobe cycle, while rd_n is still low.
      if (enable && (r_state == ST_D_STROBE) && w_tmr_zero) begin
        r_capture <= bus_in;
      end
      bus_out  <= w_next_addr_ph ? w_addr_sel : 8'h00;
      bus_oe   <= w_next_addr_ph;
      rtc_cs_n <= w_next_cs ? 1'b0 : RTC_CS_N_INACTIVE;
      rtc_ad   <= w_next_data_ph;
      rtc_wr_n <= (w_next_state == ST_A_STROBE) ? 1'b0 : RTC_WR_N_INACTIVE;
      rtc_rd_n <= (w_next_state == ST_D_STROBE) ? 1'b0 : RTC_RD_N_INACTIVE;
      done     <= (w_next_state == ST_DONE);
      busy     <= (w_next_state != ST_IDLE);
      if (w_next_state == ST_DONE) begin
        data_out <= r_capture;
        bcd_ok   <= is_bcd(r_capture);
      end
    end
  end

endmodule

// File: tb/tb_rtc_reg_reader.sv
// tb/tb_rtc_reg_reader.sv - self-checking bench for rtc_reg_reader
module tb_rtc_reg_reader;

  localparam int LAT   = 2 * (2 + 4 + 2) + 2;
  localparam int LAT_F = 2 * (1 + 1 + 1) + 2;
  localparam int TURN_CYC = 2 + 4 + 2 + 1;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       start, start_f;
  logic [7:0] addr, addr_f;
  logic [7:0] model_val, model_f;
  logic [7:0] bus_in, bus_in_f;

  logic [7:0] bus_out, data_out, bus_out_f, data_out_f;
  logic bus_oe, rtc_cs_n, rtc_ad, rtc_wr_n, rtc_rd_n, done, busy, bcd_ok;
  logic bus_oe_f, rtc_cs_n_f, rtc_ad_f, rtc_wr_n_f, rtc_rd_n_f, done_f, busy_f, bcd_ok_f;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;

  always #5 clk = ~clk;

  // RTC model: drives the register value only while the read strobe is low
  assign bus_in   = rtc_rd_n   ? 8'hFF : model_val;
  assign bus_in_f = rtc_rd_n_f ? 8'hFF : model_f;

  rtc_reg_reader dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .addr(addr),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .rtc_cs_n(rtc_cs_n),
    .rtc_ad(rtc_ad), .rtc_wr_n(rtc_wr_n), .rtc_rd_n(rtc_rd_n), .data_out(data_out),
    .done(done), .busy(busy), .bcd_ok(bcd_ok)
  );

  rtc_reg_reader #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_f (
    .clk(clk), .reset(reset), .enable(enable), .start(start_f), .addr(addr_f),
    .bus_in(bus_in_f), .bus_out(bus_out_f), .bus_oe(bus_oe_f), .rtc_cs_n(rtc_cs_n_f),
    .rtc_ad(rtc_ad_f), .rtc_wr_n(rtc_wr_n_f), .rtc_rd_n(rtc_rd_n_f), .data_out(data_out_f),
    .done(done_f), .busy(busy_f), .bcd_ok(bcd_ok_f)
  );

  function automatic logic bcd_ref(input logic [7:0] v);
    return (v[7:4] < 4'd10) && (v[3:0] < 4'd10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and scoreboard
  always @(negedge clk) begin
    chk("oe_rd_overlap", 32'(bus_oe & ~rtc_rd_n), 32'd0);
    chk("oe_rd_overlap_f", 32'(bus_oe_f & ~rtc_rd_n_f), 32'd0);
    if (!reset && enable && start && !busy) sb_q.push_back(model_val);
    if (done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("data_out", 32'(data_out), 32'(sb_exp));
        chk("bcd_ok", 32'(bcd_ok), 32'(bcd_ref(sb_exp)));
      end
    end
  end

  task automatic do_read(input logic [7:0] a, input logic [7:0] v);
    int n, wr_low, rd_low, addr_bad;
    bit got;
    n = 0; wr_low = 0; rd_low = 0; addr_bad = 0; got = 0;
    @(posedge clk); #1 start = 1'b1; addr = a; model_val = v;
    @(posedge clk); #1 start = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (!rtc_wr_n) begin
        wr_low++;
        if (bus_out !== a || !bus_oe || rtc_ad || rtc_cs_n) addr_bad++;
      end
      if (!rtc_rd_n) rd_low++;
      if (n == TURN_CYC) begin
        chk("turn_bus_oe", 32'(bus_oe), 32'd0);
        chk("turn_cs_n", 32'(rtc_cs_n), 32'd0);
      end
      if (done) got = 1;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("wr_low_cycles", 32'(wr_low), 32'd4);
    chk("rd_low_cycles", 32'(rd_low), 32'd4);
    chk("addr_phase", 32'(addr_bad), 32'd0);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("cs_n_after_done", 32'(rtc_cs_n), 32'd1);
  endtask

  task automatic do_read_f(input logic [7:0] a, input logic [7:0] v);
    int n, wr_low, rd_low;
    bit got;
    n = 0; wr_low = 0; rd_low = 0; got = 0;
    @(posedge clk); #1 start_f = 1'b1; addr_f = a; model_f = v;
    @(posedge clk); #1 start_f = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (!rtc_wr_n_f) begin
        wr_low++;
        chk("f_bus_out", 32'(bus_out_f), 32'(a));
      end
      if (!rtc_rd_n_f) rd_low++;
      if (done_f) begin
        got = 1;
        chk("f_data_out", 32'(data_out_f), 32'(v));
        chk("f_bcd_ok", 32'(bcd_ok_f), 32'(bcd_ref(v)));
      end
    end
    chk("f_latency", 32'(n), 32'(LAT_F));
    chk("f_wr_low", 32'(wr_low), 32'd1);
    chk("f_rd_low", 32'(rd_low), 32'd1);
  endtask

  task automatic abort_in_dstrobe(input bit use_reset, input logic [7:0] v);
    int dc;
    @(posedge clk); #1 start = 1'b1; addr = 8'h02; model_val = v;
    @(posedge clk); #1 start = 1'b0;
    // now in cycle 1; D_STROBE occupies cycles 12..15
    repeat (12) @(posedge clk);
    #1;
    chk("abort_in_dstrobe", 32'(rtc_rd_n), 32'd0);
    if (use_reset) reset = 1'b1; else enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    enable = 1'b1;
    sb_q.delete();
    @(negedge clk);
    dc = done_cnt;
    chk("abort_cs_n", 32'(rtc_cs_n), 32'd1);
    chk("abort_rd_n", 32'(rtc_rd_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_bus_oe", 32'(bus_oe), 32'd0);
    if (!use_reset) begin
      chk("abort_data_held", 32'(data_out), 32'h31);
      chk("abort_bcd_held", 32'(bcd_ok), 32'd1);
    end
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, dn, lows, hi_run, min_gap, n;
    bit prev_cs_n;
    reset = 1'b1; enable = 1'b1; start = 1'b0; addr = 8'h00; model_val = 8'h00;
    start_f = 1'b0; addr_f = 8'h00; model_f = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(rtc_cs_n && rtc_wr_n && rtc_rd_n)) bad++;
    end
    chk("idle_strobes_high", 32'(bad), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_rtc_ad", 32'(rtc_ad), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd_ok", 32'(bcd_ok), 32'd0);

    do_read(8'h21, 8'h45);
    do_read(8'h21, 8'h5A);
    do_read(8'h09, 8'h99);

    // start held for 40 cycles: accepts at edges 0, 19 and 38; two finish in the window
    dn = 0; lows = 0; hi_run = 0; min_gap = 1000; prev_cs_n = 1'b1;
    @(posedge clk); #1 start = 1'b1; addr = 8'h22; model_val = 8'h31;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
      if (rtc_cs_n) hi_run++;
      else if (prev_cs_n) begin
        if (lows > 0 && hi_run < min_gap) min_gap = hi_run;
        lows++;
        hi_run = 0;
      end
      prev_cs_n = rtc_cs_n;
    end
    start = 1'b0;
    chk("b2b_done_in_window", 32'(dn), 32'd2);
    chk("b2b_transactions_started", 32'(lows), 32'd3);
    chk("b2b_cs_gap", 32'(min_gap >= 1), 32'd1);
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("b2b_drained", 32'(busy), 32'd0);
    chk("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

    abort_in_dstrobe(1'b0, 8'h12);
    abort_in_dstrobe(1'b1, 8'h34);
    do_read(8'h04, 8'h23);

    do_read_f(8'h09, 8'h99);
    do_read_f(8'h07, 8'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
